ejtag_pracc_bridge: RTL

- Downstream consumer of the EJTAG DAP's ADDRESS, DATA and CONTROL data registers.
- On each DR update strobe it latches the register's parallel value.
- A CONTROL update with PrAcc=1 launches one processor-bus access (read or write) into SchoolMIPS memory over a req/ack handshake.
- It returns read data and status as the capture values the DAP loads on Capture-DR.

---
 rtl/ejtag_pracc_bridge.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ejtag_pracc_bridge.sv
// ejtag_pracc_bridge
//   Bridges the EJTAG DAP's ADDRESS / DATA / CONTROL data registers to a simple
//   req/ack processor bus. A CONTROL update with PrAcc=1 launches one read or
//   write. Status and read data are returned as Capture-DR values.
// Ports
//   ICLK, TRST                      clock, async active-high reset
//   update_addr/addr_in             latch ADDRESS register value
//   update_data/data_in             latch DATA register value
//   update_ctrl/ctrl_in             CONTROL: [19] PRnW, [18] PrAcc, [6:5] Psz, [1:0] W1C err/done
//   addr/data/ctrl_capture          Capture-DR values
//   mem_req/we/addr/be/wdata        bus request side
//   mem_ack/mem_rdata               bus completion side
module ejtag_pracc_bridge #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          ICLK,
   input  logic          TRST,
   input  logic          update_addr,
   input  logic [AW-1:0] addr_in,
   input  logic          update_data,
   input  logic [DW-1:0] data_in,
   input  logic          update_ctrl,
   input  logic [31:0]   ctrl_in,
   output logic [AW-1:0] addr_capture,
   output logic [DW-1:0] data_capture,
   output logic [31:0]   ctrl_capture,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [3:0]    mem_be,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic StIdle = 1'b0;
   localparam logic StBusy = 1'b1;

   // Counter only ever needs to reach TIMEOUT-1.
   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic          state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic          prnw_q, prnw_d;
   logic [1:0]    psz_q, psz_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [1:0]    start_lsb;
   logic          illegal;
   logic          timeout_hit;

   // A start coinciding with update_addr checks the freshly latched address.
   assign start_lsb = update_addr ? addr_in[1:0] : addr_q[1:0];

   always_comb begin
      illegal = 1'b0;
      unique case (ctrl_in[6:5])
         2'b00:   illegal = 1'b0;
         2'b01:   illegal = start_lsb[0];
         2'b10:   illegal = (start_lsb != 2'b00);
         default: illegal = 1'b1;
      endcase
   end

   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      prnw_d  = prnw_q;
      psz_d   = psz_q;
      done_d  = done_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      if (state_q == StIdle) begin
         if (update_addr) addr_d = addr_in;
         if (update_data) data_d = data_in;
         if (update_ctrl) begin
            if (ctrl_in[1]) err_d = 1'b0;
            if (ctrl_in[0]) done_d = 1'b0;
            if (ctrl_in[18]) begin
               prnw_d = ctrl_in[19];
               psz_d  = ctrl_in[6:5];
               if (illegal) begin
                  err_d = 1'b1;
               end else begin
                  state_d = StBusy;
                  cnt_d   = '0;
                  done_d  = 1'b0;
               end
            end
         end
      end else begin
         // Ack takes priority over a simultaneous timeout.
         if (mem_ack) begin
            state_d = StIdle;
            done_d  = 1'b1;
            if (prnw_q) data_d = mem_rdata;
         end else if (timeout_hit) begin
            state_d = StIdle;
            err_d   = 1'b1;
            done_d  = 1'b0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge ICLK or posedge TRST) begin
      if (TRST) begin
         state_q <= StIdle;
         addr_q  <= '0;
         data_q  <= '0;
         prnw_q  <= 1'b0;
         psz_q   <= 2'b00;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         prnw_q  <= prnw_d;
         psz_q   <= psz_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   logic busy;
   logic [3:0] be_raw;

   assign busy = (state_q == StBusy);

   always_comb begin
      be_raw = 4'b0000;
      unique case (psz_q)
         2'b00:   be_raw = 4'b0001 << addr_q[1:0];
         2'b01:   be_raw = addr_q[1] ? 4'b1100 : 4'b0011;
         default: be_raw = 4'b1111;
      endcase
   end

   assign mem_req   = busy;
   assign mem_we    = busy & ~prnw_q;
   assign mem_addr  = {addr_q[AW-1:2], 2'b00};
   assign mem_be    = busy ? be_raw : 4'b0000;
   assign mem_wdata = data_q;

   assign addr_capture = addr_q;
   assign data_capture = data_q;
   assign ctrl_capture = {12'b0, prnw_q, busy, 11'b0, psz_q, 3'b0, err_q, done_q};

   logic unused_ctrl;
   assign unused_ctrl = ^{ctrl_in[31:20], ctrl_in[17:7], ctrl_in[4:2]};

endmodule
